// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with programmable pattern,
// overlap/non-overlap matching and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b0110,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_bit,
    input  logic               din_valid,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               pat_load,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               detect_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int FILL_W = $clog2(PAT_LEN);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-2:0] hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] window;
    logic               accept;
    logic               full;
    logic               match;
    logic [CNT_W-1:0]   cnt_next;

    assign window = {hist, din_bit};
    assign accept = din_valid & ~pat_load;
    assign full   = (fill == FILL_W'(PAT_LEN - 1));
    assign match  = accept & full & (window == pat_reg);

    // Clear wins over increment, but a coincident match still counts.
    always_comb begin
        cnt_next = match_count;
        if (count_clr)
            cnt_next = match ? CNT_W'(1) : '0;
        else if (match && !(&match_count))
            cnt_next = match_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg     <= RESET_PAT;
            hist        <= '0;
            fill        <= '0;
            detect_out  <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            detect_out  <= match;
            match_count <= cnt_next;
            count_sat   <= &cnt_next;
            if (pat_load) begin
                pat_reg <= pattern;
                fill    <= '0;
            end else if (accept) begin
                hist <= window[PAT_LEN-2:0];
                if (match && !overlap_en)
                    fill <= '0;
                else if (!full)
                    fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed vector bench for seq_detect_param: default instance plus a
// CNT_W=2 instance for counter saturation corners.
module tb_seq_detect_param;

    typedef struct {
        logic       r;
        logic       b;
        logic       v;
        logic       l;
        logic [3:0] p;
        logic       o;
        logic       c;
        logic       d;
        logic [7:0] n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_bit = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       pat_load = 1'b0;
    logic       overlap_en = 1'b1;
    logic       count_clr = 1'b0;

    logic       det_a, sat_a, det_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    seq_detect_param dut_a (
        .clk(clk), .rst(rst), .din_bit(din_bit), .din_valid(din_valid),
        .pattern(pattern), .pat_load(pat_load), .overlap_en(overlap_en),
        .count_clr(count_clr), .detect_out(det_a), .match_count(cnt_a),
        .count_sat(sat_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .din_bit(din_bit), .din_valid(din_valid),
        .pattern(pattern), .pat_load(pat_load), .overlap_en(overlap_en),
        .count_clr(count_clr), .detect_out(det_b), .match_count(cnt_b),
        .count_sat(sat_b)
    );

    function automatic void add(logic r, logic b, logic v, logic l,
                                logic [3:0] p, logic o, logic c,
                                logic d, logic [7:0] n);
        vec_t x;
        x.r = r; x.b = b; x.v = v; x.l = l; x.p = p;
        x.o = o; x.c = c; x.d = d; x.n = n;
        vq.push_back(x);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        @(negedge clk);
        rst        = x.r;
        din_bit    = x.b;
        din_valid  = x.v;
        pat_load   = x.l;
        pattern    = x.p;
        overlap_en = x.o;
        count_clr  = x.c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t h;
        int   eb_cnt[7] = '{0, 0, 0, 1, 2, 3, 3};
        int   eb_sat[7] = '{0, 0, 0, 0, 0, 1, 1};
        int   eb_det[7] = '{0, 0, 0, 1, 1, 1, 1};

        // overlap stream 0110110
        add(1,0,0,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 1,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,0,1,0,4'h0,1,0, 1,2);
        add(0,0,0,0,4'h0,1,0, 0,2);
        add(0,0,0,0,4'h0,1,1, 0,0);
        // non-overlap stream
        add(1,0,0,0,4'h0,0,0, 0,0);
        add(0,0,1,0,4'h0,0,0, 0,0);
        add(0,1,1,0,4'h0,0,0, 0,0);
        add(0,1,1,0,4'h0,0,0, 0,0);
        add(0,0,1,0,4'h0,0,0, 1,1);
        add(0,1,1,0,4'h0,0,0, 0,1);
        add(0,1,1,0,4'h0,0,0, 0,1);
        add(0,0,1,0,4'h0,0,0, 0,1);
        // gaps are transparent
        add(1,0,0,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,1,0,0,4'h0,1,0, 0,0);
        add(0,0,0,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 1,1);
        // load 1011 mid-stream, offered bit would finish 0110
        add(0,0,1,0,4'h0,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,0,1,1,4'hB,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,0,1,0,4'h0,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 0,1);
        add(0,1,1,0,4'h0,1,0, 1,2);
        add(0,0,1,0,4'h0,1,0, 0,2);
        add(0,1,1,0,4'h0,1,0, 0,2);
        add(0,1,1,0,4'h0,1,0, 1,3);
        add(0,0,1,0,4'h0,1,0, 0,3);
        // reset mid-stream loses history
        add(1,0,0,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(1,0,1,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,1,1,0,4'h0,1,0, 0,0);
        add(0,0,1,0,4'h0,1,0, 1,1);

        foreach (vq[i]) begin
            drive(vq[i]);
            chk($sformatf("v%0d_det", i), 32'(det_a), 32'(vq[i].d));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vq[i].n));
        end

        // saturation on the CNT_W=2 instance with pattern 1111
        h = '{r:1, b:0, v:0, l:0, p:4'h0, o:1, c:0, d:0, n:0};
        drive(h);
        chk("rst_sat_b", 32'(sat_b), 0);
        h.r = 0; h.l = 1; h.p = 4'hF;
        drive(h);
        h.l = 0; h.p = 4'h0; h.v = 1; h.b = 1;
        for (int k = 0; k < 7; k++) begin
            drive(h);
            chk($sformatf("s%0d_det", k), 32'(det_b), 32'(eb_det[k]));
            chk($sformatf("s%0d_cnt", k), 32'(cnt_b), 32'(eb_cnt[k]));
            chk($sformatf("s%0d_sat", k), 32'(sat_b), 32'(eb_sat[k]));
        end
        h.c = 1;
        drive(h);
        chk("clr_match_det", 32'(det_b), 1);
        chk("clr_match_cnt", 32'(cnt_b), 1);
        chk("clr_match_sat", 32'(sat_b), 0);
        chk("wide_cnt", 32'(cnt_a), 1);
        chk("wide_sat", 32'(sat_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
